// File: rtl/z3_bridge_if.sv
// rtl/z3_bridge_if.sv - host solver command/response channel used by z3_bridge
interface z3_bridge_if;
  logic        host_cmd_valid;
  logic        host_cmd_ready;
  logic [31:0] host_cmd_addr;
  logic [3:0]  host_cmd_tag;
  logic        host_rsp_valid;
  logic        host_rsp_ready;
  logic [31:0] host_rsp_result;
  logic        host_rsp_sat;
  logic [3:0]  host_rsp_tag;
  logic        host_rsp_error;

  // bridge side: issues commands, consumes responses
  modport master (
    output host_cmd_valid, host_cmd_addr, host_cmd_tag, host_rsp_ready,
    input  host_cmd_ready, host_rsp_valid, host_rsp_result, host_rsp_sat,
           host_rsp_tag, host_rsp_error
  );

  // host solver side
  modport slave (
    input  host_cmd_valid, host_cmd_addr, host_cmd_tag, host_rsp_ready,
    output host_cmd_ready, host_rsp_valid, host_rsp_result, host_rsp_sat,
           host_rsp_tag, host_rsp_error
  );
endinterface

// File: rtl/z3_bridge.sv
// rtl/z3_bridge.sv - request FIFO and tagged host solver bridge; Z3_BRIDGE_CHAIN_HASH_EN chains the certificate hash
module z3_bridge #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [15:0] TIMEOUT = 16'hF000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        z3_req,
  input  logic [31:0] z3_formula_addr,
  output logic        z3_ack,
  output logic [31:0] z3_result,
  output logic        z3_sat,
  output logic [31:0] z3_cert_hash,
  z3_bridge_if.master host,
  output logic        busy,
  output logic        bridge_err,
  output logic [7:0]  drop_count
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [31:0] TIMEOUT_RESULT = 32'h0000_2001;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESPOND} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   cmd_addr_q, cmd_addr_d;
  logic [3:0]    cmd_tag_q, cmd_tag_d;
  logic [3:0]    tag_ctr_q, tag_ctr_d;
  logic [15:0]   timer_q, timer_d;
  logic          z3_ack_q;
  logic [31:0]   z3_result_q, z3_cert_hash_q;
  logic          z3_sat_q, busy_q, bridge_err_q;
  logic [7:0]    drop_count_q;

  logic          fifo_full, push, pop, drop;
  logic          rsp_hit, respond_go, new_sat, new_err;
  logic [31:0]   new_result, hash_next;

  // fullness is judged at the start of the cycle; a same-cycle pop never makes room
  assign fifo_full = (count_q == FULL_CNT);
  assign push      = z3_req && !fifo_full;
  assign drop      = z3_req && fifo_full;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign host.host_cmd_valid = (state_q == ISSUE);
  assign host.host_rsp_ready = (state_q == WAIT_RSP);
  assign host.host_cmd_addr  = cmd_addr_q;
  assign host.host_cmd_tag   = cmd_tag_q;

  assign z3_ack       = z3_ack_q;
  assign z3_result    = z3_result_q;
  assign z3_sat       = z3_sat_q;
  assign z3_cert_hash = z3_cert_hash_q;
  assign busy         = busy_q;
  assign bridge_err   = bridge_err_q;
  assign drop_count   = drop_count_q;

  // next-state and transaction bookkeeping for the host handshake
  always_comb begin
    state_d    = state_q;
    cmd_addr_d = cmd_addr_q;
    cmd_tag_d  = cmd_tag_q;
    tag_ctr_d  = tag_ctr_q;
    timer_d    = timer_q;
    respond_go = 1'b0;
    new_result = '0;
    new_sat    = 1'b0;
    new_err    = 1'b0;
    rsp_hit    = host.host_rsp_valid && (host.host_rsp_tag == cmd_tag_q);
    case (state_q)
      IDLE: begin
        if (pop) begin
          cmd_addr_d = fifo_q[rd_ptr_q];
          cmd_tag_d  = tag_ctr_q;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (host.host_cmd_ready) begin
          tag_ctr_d = tag_ctr_q + 4'd1;
          timer_d   = TIMEOUT;
          state_d   = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        timer_d = (timer_q != 16'd0) ? timer_q - 16'd1 : 16'd0;
        // a matching response takes priority over a timeout in the same cycle;
        // responses carrying a stale tag are consumed and ignored
        if (rsp_hit) begin
          new_result = host.host_rsp_result;
          new_sat    = host.host_rsp_sat && !host.host_rsp_error;
          new_err    = host.host_rsp_error;
          respond_go = 1'b1;
          state_d    = RESPOND;
        end else if (timer_q <= 16'd1) begin
          new_result = TIMEOUT_RESULT;
          new_sat    = 1'b0;
          new_err    = 1'b1;
          respond_go = 1'b1;
          state_d    = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef Z3_BRIDGE_CHAIN_HASH_EN
  logic [31:0] chain_q;

  assign hash_next = {chain_q[26:0], chain_q[31:27]} ^ new_result ^ cmd_addr_q ^ {31'b0, new_sat};

  // chain register advances once per completed request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else if (respond_go) chain_q <= hash_next;
  end
`else
  assign hash_next = new_result ^ cmd_addr_q;
`endif

  // request FIFO storage; contents need no reset because count_q gates every read
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= z3_formula_addr;
  end

  // FSM state, FIFO pointers and transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_addr_q <= '0;
      cmd_tag_q  <= '0;
      tag_ctr_q  <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_tag_q  <= cmd_tag_d;
      tag_ctr_q  <= tag_ctr_d;
      timer_q    <= timer_d;
    end
  end

  // registered engine-facing outputs; the ack pulse coincides with the RESPOND state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z3_ack_q       <= 1'b0;
      z3_result_q    <= '0;
      z3_sat_q       <= 1'b0;
      z3_cert_hash_q <= '0;
      busy_q         <= 1'b0;
      bridge_err_q   <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      z3_ack_q <= respond_go;
      if (respond_go) begin
        z3_result_q    <= new_result;
        z3_sat_q       <= new_sat;
        z3_cert_hash_q <= hash_next;
      end
      if (drop && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 8'd1;
      if (drop || (respond_go && new_err)) bridge_err_q <= 1'b1;
      busy_q <= (state_d != IDLE) || (count_d != '0);
    end
  end
endmodule

// File: tb/tb_z3_bridge.sv
// tb/tb_z3_bridge.sv - self-checking bench for z3_bridge with a queue-based reference model
module tb_z3_bridge;
  localparam int          DEPTH = 4;
  localparam logic [15:0] TOUT  = 16'd12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        z3_req;
  logic [31:0] z3_formula_addr;
  logic        z3_ack;
  logic [31:0] z3_result;
  logic        z3_sat;
  logic [31:0] z3_cert_hash;
  logic        busy, bridge_err;
  logic [7:0]  drop_count;

  z3_bridge_if hif ();

  z3_bridge #(.DEPTH(DEPTH), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .z3_req(z3_req), .z3_formula_addr(z3_formula_addr),
    .z3_ack(z3_ack), .z3_result(z3_result), .z3_sat(z3_sat), .z3_cert_hash(z3_cert_hash),
    .host(hif),
    .busy(busy), .bridge_err(bridge_err), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [3:0]  m_tag;
  bit          m_err;
  int          m_drop;
  logic [31:0] m_chain;
  logic [31:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tag = 4'd0; m_err = 1'b0; m_drop = 0; m_chain = 32'd0; q.delete();
  endtask

  task automatic model_hash(input logic [31:0] r, input logic [31:0] a, input bit s,
                            output logic [31:0] h);
`ifdef Z3_BRIDGE_CHAIN_HASH_EN
    h = ((m_chain << 5) | (m_chain >> 27)) ^ r ^ a ^ {31'b0, s};
    m_chain = h;
`else
    h = r ^ a ^ (s ? 32'd0 : 32'd0);
`endif
  endtask

  // enqueue one request in the model, honouring FIFO capacity
  task automatic model_push(input logic [31:0] a);
    if (q.size() < DEPTH) q.push_back(a);
    else begin
      m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      m_err  = 1'b1;
    end
  endtask

  task automatic send_req(input logic [31:0] a);
    z3_req = 1'b1; z3_formula_addr = a;
    @(negedge clk);
    z3_req = 1'b0;
  endtask

  task automatic wait_cmd();
    int k = 0;
    while (hif.host_cmd_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    chk("cmd_valid_seen", {31'b0, hif.host_cmd_valid}, 32'd1);
  endtask

  // host side of one transaction; kind 0=normal, 1=host error, 2=no response
  task automatic serve(input logic [31:0] a, input int rdly, input int nbad, input logic [3:0] xr,
                       input int kind, input logic [31:0] r, input bit s, input int t0);
    int          k;
    bit          got;
    logic [3:0]  ct;
    logic [31:0] er, eh;
    bit          es;
    wait_cmd();
    ct = m_tag;
    chk("cmd_addr", hif.host_cmd_addr, a);
    chk("cmd_tag", {28'b0, hif.host_cmd_tag}, {28'b0, ct});
    if (rdly > 0) begin
      repeat (rdly) @(negedge clk);
      chk("cmd_hold_valid", {31'b0, hif.host_cmd_valid}, 32'd1);
      chk("cmd_hold_addr", hif.host_cmd_addr, a);
    end
    hif.host_cmd_ready = 1'b1;
    @(negedge clk);
    hif.host_cmd_ready = 1'b0;
    m_tag = m_tag + 4'd1;
    chk("rsp_ready", {31'b0, hif.host_rsp_ready}, 32'd1);
    k = 0; got = 1'b0;
    while (!got && k < int'(TOUT) + 10) begin
      if (z3_ack === 1'b1) got = 1'b1;
      else begin
        if (k < nbad) begin
          hif.host_rsp_valid = 1'b1; hif.host_rsp_tag = ct ^ xr;
          hif.host_rsp_result = $urandom; hif.host_rsp_sat = 1'b1; hif.host_rsp_error = 1'b0;
        end else if (k == nbad && kind != 2) begin
          hif.host_rsp_valid = 1'b1; hif.host_rsp_tag = ct;
          hif.host_rsp_result = r; hif.host_rsp_sat = s; hif.host_rsp_error = (kind == 1);
        end else hif.host_rsp_valid = 1'b0;
        @(negedge clk);
        k++;
      end
    end
    hif.host_rsp_valid = 1'b0;
    chk("ack_seen", {31'b0, got}, 32'd1);
    if (kind == 2) begin er = 32'h0000_2001; es = 1'b0; m_err = 1'b1; end
    else if (kind == 1) begin er = r; es = 1'b0; m_err = 1'b1; end
    else begin er = r; es = s; end
    model_hash(er, a, es, eh);
    chk("ack_wait", k, (kind == 2) ? int'(TOUT) : nbad + 1);
    if (t0 >= 0) chk("latency", cyc - t0, 3 + rdly + ((kind == 2) ? int'(TOUT) : nbad + 1));
    chk("z3_result", z3_result, er);
    chk("z3_sat", {31'b0, z3_sat}, {31'b0, es});
    chk("z3_cert_hash", z3_cert_hash, eh);
    chk("bridge_err", {31'b0, bridge_err}, {31'b0, m_err});
    @(negedge clk);
    chk("ack_pulse", {31'b0, z3_ack}, 32'd0);
    chk("busy_after", {31'b0, busy}, {31'b0, q.size() != 0});
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ack"}, {31'b0, z3_ack}, 32'd0);
    chk({tag, "_result"}, z3_result, 32'd0);
    chk({tag, "_sat"}, {31'b0, z3_sat}, 32'd0);
    chk({tag, "_hash"}, z3_cert_hash, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_err"}, {31'b0, bridge_err}, 32'd0);
    chk({tag, "_drop"}, {24'b0, drop_count}, 32'd0);
    chk({tag, "_cmd_valid"}, {31'b0, hif.host_cmd_valid}, 32'd0);
    chk({tag, "_rsp_ready"}, {31'b0, hif.host_rsp_ready}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; z3_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int          t0, kind, rdly, nbad;
    logic [31:0] a, r;
    logic [3:0]  xr, late_tag;
    bit          s;
    rst_n = 1'b0; z3_req = 1'b0; z3_formula_addr = '0;
    hif.host_cmd_ready = 1'b0; hif.host_rsp_valid = 1'b0; hif.host_rsp_result = '0;
    hif.host_rsp_sat = 1'b0; hif.host_rsp_tag = '0; hif.host_rsp_error = 1'b0;
    do_reset();
    check_idle_outputs("reset");

    // single request, immediate host, minimum latency
    t0 = cyc; send_req(32'h100);
    serve(32'h100, 0, 0, 4'd1, 0, 32'h5, 1'b1, t0);
    chk("basic_result", z3_result, 32'h5);
    chk("basic_sat", {31'b0, z3_sat}, 32'd1);
`ifndef Z3_BRIDGE_CHAIN_HASH_EN
    chk("basic_hash", z3_cert_hash, 32'h105);
`endif

    // host never answers
    t0 = cyc; send_req(32'h200);
    serve(32'h200, 0, 0, 4'd1, 2, 32'h0, 1'b0, t0);
    chk("timeout_result", z3_result, 32'h2001);
    chk("timeout_err", {31'b0, bridge_err}, 32'd1);

    // overflow: one request stalled in ISSUE, then five back-to-back
    do_reset();
    send_req(32'hA000_0000);
    wait_cmd();
    for (int i = 0; i < 5; i++) begin
      z3_req = 1'b1; z3_formula_addr = 32'hA000_0001 + i;
      model_push(32'hA000_0001 + i);
      @(negedge clk);
    end
    z3_req = 1'b0;
    chk("ovf_drop", {24'b0, drop_count}, m_drop);
    chk("ovf_err", {31'b0, bridge_err}, {31'b0, m_err});
    chk("ovf_busy", {31'b0, busy}, 32'd1);
    serve(32'hA000_0000, 0, 0, 4'd1, 0, 32'h11, 1'b1, -1);
    while (q.size() != 0) begin
      a = q.pop_front();
      serve(a, 0, 0, 4'd1, 0, a + 32'd7, a[0], -1);
    end

    // drop counter saturation
    send_req(32'hB000_0000);
    wait_cmd();
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      z3_req = 1'b1; z3_formula_addr = a;
      model_push(a);
      @(negedge clk);
    end
    z3_req = 1'b0;
    chk("sat_drop", {24'b0, drop_count}, m_drop);
    serve(32'hB000_0000, 0, 0, 4'd1, 0, 32'h22, 1'b0, -1);
    while (q.size() != 0) begin
      a = q.pop_front();
      serve(a, 1, 0, 4'd1, 0, ~a, 1'b1, -1);
    end

    // reset while waiting for the host response
    send_req(32'h0000_0BAD);
    wait_cmd();
    late_tag = m_tag;
    hif.host_cmd_ready = 1'b1;
    @(negedge clk);
    hif.host_cmd_ready = 1'b0;
    chk("mid_rsp_ready", {31'b0, hif.host_rsp_ready}, 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle_outputs("mid_rst");
    hif.host_rsp_valid = 1'b1; hif.host_rsp_tag = late_tag;
    hif.host_rsp_result = 32'h1234; hif.host_rsp_sat = 1'b1; hif.host_rsp_error = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_ack_after_rst", {31'b0, z3_ack}, 32'd0);
    end
    hif.host_rsp_valid = 1'b0;

    // stale tag 3 while expecting tag 0, then the matching response
    t0 = cyc; send_req(32'h300);
    serve(32'h300, 0, 1, 4'd3, 0, 32'hCAFE, 1'b1, t0);
    chk("stale_result", z3_result, 32'hCAFE);

    // host reports an error: sat forced low, sticky error
    t0 = cyc; send_req(32'h400);
    serve(32'h400, 2, 0, 4'd1, 1, 32'h77, 1'b1, t0);

    // randomized transactions, tags wrap past 15
    for (int it = 0; it < 24; it++) begin
      a = $urandom; r = $urandom; s = 1'($urandom_range(0, 1));
      kind = ($urandom_range(0, 7) == 0) ? 2 : (($urandom_range(0, 5) == 0) ? 1 : 0);
      rdly = $urandom_range(0, 3); nbad = $urandom_range(0, 2);
      xr = 4'($urandom_range(1, 15));
      t0 = cyc; send_req(a);
      serve(a, rdly, nbad, xr, kind, r, s, t0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef Z3_BRIDGE_CHAIN_HASH_EN
    do_reset();
    t0 = cyc; send_req(32'h1);
    serve(32'h1, 0, 0, 4'd1, 0, 32'h2, 1'b0, t0);
    chk("chain_hash0", z3_cert_hash, 32'h3);
    t0 = cyc; send_req(32'h1);
    serve(32'h1, 0, 0, 4'd1, 0, 32'h2, 1'b0, t0);
    chk("chain_hash1", z3_cert_hash, 32'h63);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
